// File: rtl/nios2_led_sequencer.sv
// LED pattern sequencer: CPU-loaded pattern table replayed as Avalon-MM master
// writes to the PIO data register, one write per programmed period.
module nios2_led_sequencer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned LED_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic [1:0]  avm_address,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest
);

    localparam int unsigned IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        WAIT
    } state_t;

    state_t           state;
    logic             ctrl_run;
    logic             ctrl_loop;
    logic             ctrl_ie;
    logic             done;
    logic [31:0]      period;
    logic [4:0]       length;
    logic [LED_W-1:0] pattern [DEPTH];
    logic [3:0]       index;
    logic [31:0]      count;

    logic             wr_en;
    logic             ctrl_wr;
    logic             status_wr;
    logic             abort_now;
    logic             pat_hit;
    logic [IW-1:0]    pat_idx;
    logic [IW-1:0]    idx_sel;
    logic [4:0]       len_eff;
    logic [31:0]      period_eff;
    logic             last;
    logic             busy;
    logic             accept;

    assign wr_en      = chipselect & ~write_n;
    assign ctrl_wr    = wr_en && (address == 4'd0);
    assign status_wr  = wr_en && (address == 4'd1);
    assign abort_now  = ctrl_wr && !writedata[0];
    assign pat_hit    = address[3] && (32'(address[2:0]) < DEPTH);
    assign pat_idx    = IW'(address[2:0]);
    assign idx_sel    = index[IW-1:0];
    assign period_eff = (period == 32'd0) ? 32'd1 : period;
    assign busy       = (state != IDLE);
    assign accept     = avm_write && !avm_waitrequest;
    assign irq        = done & ctrl_ie;
    assign avm_address = 2'd0;

    always_comb begin
        len_eff = length;
        if (length == 5'd0) begin
            len_eff = 5'd1;
        end else if (length > 5'(DEPTH)) begin
            len_eff = 5'(DEPTH);
        end
    end

    assign last = ({1'b0, index} == (len_eff - 5'd1));

    // Configuration registers; run/done live with the FSM since both sides touch them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_loop <= 1'b0;
            ctrl_ie   <= 1'b0;
            period    <= '0;
            length    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pattern[i] <= '0;
            end
        end else if (wr_en) begin
            case (address)
                4'd0: begin
                    ctrl_loop <= writedata[1];
                    ctrl_ie   <= writedata[2];
                end
                4'd2: period <= writedata;
                4'd3: length <= writedata[4:0];
                default: begin
                    if (pat_hit) begin
                        pattern[pat_idx] <= writedata[LED_W-1:0];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ctrl_run      <= 1'b0;
            done          <= 1'b0;
            index         <= '0;
            count         <= '0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
        end else begin
            if (status_wr && writedata[1]) begin
                done <= 1'b0;
            end
            if (busy && abort_now) begin
                ctrl_run <= 1'b0;
            end

            // Later assignments below override the clear above, so completion wins.
            case (state)
                IDLE: begin
                    if (ctrl_wr && writedata[0]) begin
                        ctrl_run      <= 1'b1;
                        index         <= '0;
                        avm_write     <= 1'b1;
                        avm_writedata <= 32'(pattern[0]);
                        state         <= WRITE;
                    end
                end
                WRITE: begin
                    if (accept) begin
                        avm_write <= 1'b0;
                        if (!ctrl_run || abort_now) begin
                            state <= IDLE;
                        end else if (last) begin
                            if (ctrl_loop) begin
                                index <= '0;
                                count <= period_eff;
                                state <= WAIT;
                            end else begin
                                done     <= 1'b1;
                                ctrl_run <= 1'b0;
                                state    <= IDLE;
                            end
                        end else begin
                            index <= index + 4'd1;
                            count <= period_eff;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!ctrl_run || abort_now) begin
                        state <= IDLE;
                    end else if (count <= 32'd1) begin
                        avm_write     <= 1'b1;
                        avm_writedata <= 32'(pattern[idx_sel]);
                        state         <= WRITE;
                    end else begin
                        count <= count - 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            4'd0: readdata = {29'd0, ctrl_ie, ctrl_loop, ctrl_run};
            4'd1: readdata = {24'd0, index, 2'b00, done, busy};
            4'd2: readdata = period;
            4'd3: readdata = {27'd0, length};
            default: begin
                if (pat_hit) begin
                    readdata = 32'(pattern[pat_idx]);
                end
            end
        endcase
    end

endmodule

// File: tb/tb_nios2_led_sequencer.sv
// Scoreboard bench for nios2_led_sequencer: expected master writes are queued
// when a sequence is started and checked as the DUT issues them.
module tb_nios2_led_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;
    logic [1:0]  avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest = 1'b0;

    typedef struct {
        logic [31:0] data;
        int unsigned gap;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e_mon;
    int unsigned n_tests = 0;
    int unsigned n_fail = 0;
    int unsigned cyc = 0;
    int unsigned last_acc = 0;
    int unsigned acc_count = 0;
    logic [31:0] rd;

    nios2_led_sequencer #(.DEPTH(8), .LED_W(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .address         (address),
        .chipselect      (chipselect),
        .write_n         (write_n),
        .writedata       (writedata),
        .readdata        (readdata),
        .irq             (irq),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expd);
        n_tests++;
        if (act !== expd) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, expd);
        end
    endtask

    // Monitor at negedge: a request seen here with waitrequest low is accepted on the next posedge.
    always @(negedge clk) begin
        if (!reset && avm_write) begin
            if (exp_q.size() == 0) begin
                check("sb_pending", 32'(exp_q.size()), 32'd1);
            end else if (avm_waitrequest) begin
                check("stall_data", avm_writedata, exp_q[0].data);
            end else begin
                e_mon = exp_q.pop_front();
                check("wr_data", avm_writedata, e_mon.data);
                check("wr_addr", 32'(avm_address), 32'd0);
                if (e_mon.gap != 0) check("wr_gap", cyc - last_acc, e_mon.gap);
                last_acc = cyc;
                acc_count++;
            end
        end
    end

    task automatic push(input logic [31:0] d, input int unsigned gap);
        exp_t e;
        e.data = d;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        @(negedge clk);
        d = readdata;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] expd);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, d, expd);
    endtask

    task automatic wait_idle(input string tag, input int unsigned budget);
        logic [31:0] st;
        int unsigned k = 0;
        do begin
            bus_read(4'd1, st);
            k++;
        end while (st[0] && k < budget);
        check(tag, 32'(st[0]), 32'd0);
    endtask

    task automatic wait_accepts(input int unsigned n, input int unsigned budget);
        int unsigned k = 0;
        while (acc_count < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        check("accept_count", acc_count, n);
    endtask

    task automatic wait_req(input int unsigned budget);
        int unsigned k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!avm_write && k < budget);
        check("req_seen", 32'(avm_write), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_avm_write", 32'(avm_write), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        reset = 1'b0;
        read_check("rst_ctrl", 4'd0, 32'd0);
        read_check("rst_status", 4'd1, 32'd0);

        // T2 single pass
        bus_write(4'd8, 32'h01);
        bus_write(4'd9, 32'h02);
        bus_write(4'd10, 32'h04);
        bus_write(4'd3, 32'd3);
        bus_write(4'd2, 32'd5);
        bus_write(4'd4, 32'hFFFF_FFFF);
        read_check("unmapped_rd", 4'd4, 32'd0);
        read_check("pat1_rd", 4'd9, 32'h02);
        read_check("period_rd", 4'd2, 32'd5);
        push(32'h01, 0);
        push(32'h02, 6);
        push(32'h04, 6);
        bus_write(4'd0, 32'd1);
        wait_idle("t2_idle", 100);
        check("t2_drained", 32'(exp_q.size()), 32'd0);
        read_check("t2_status", 4'd1, 32'h22);
        read_check("t2_ctrl", 4'd0, 32'h0);
        bus_write(4'd1, 32'h2);
        read_check("t2_done_clr", 4'd1, 32'h20);

        // T3 stall on second write
        acc_count = 0;
        push(32'h01, 0);
        push(32'h02, 10);
        push(32'h04, 6);
        bus_write(4'd0, 32'd1);
        wait_accepts(1, 50);
        wait_req(50);
        avm_waitrequest = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        avm_waitrequest = 1'b0;
        wait_idle("t3_idle", 100);
        check("t3_drained", 32'(exp_q.size()), 32'd0);
        read_check("t3_status", 4'd1, 32'h22);
        bus_write(4'd1, 32'h2);

        // T4 loop then abort during a stalled write
        bus_write(4'd8, 32'hA5);
        bus_write(4'd9, 32'h5A);
        bus_write(4'd3, 32'd2);
        bus_write(4'd2, 32'd2);
        acc_count = 0;
        push(32'hA5, 0);
        push(32'h5A, 3);
        push(32'hA5, 3);
        push(32'h5A, 0);
        bus_write(4'd0, 32'd3);
        wait_accepts(3, 50);
        wait_req(50);
        avm_waitrequest = 1'b1;
        bus_write(4'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        avm_waitrequest = 1'b0;
        wait_idle("t4_idle", 50);
        repeat (10) @(posedge clk);
        #1;
        check("t4_drained", 32'(exp_q.size()), 32'd0);
        read_check("t4_status", 4'd1, 32'h10);
        read_check("t4_ctrl", 4'd0, 32'h0);

        // T5 boundaries: PERIOD=0, LENGTH=0, then LENGTH clamped to DEPTH
        for (int i = 0; i < 8; i++) begin
            bus_write(4'(8 + i), 32'(8'h11 * (i + 1)));
        end
        bus_write(4'd2, 32'd0);
        bus_write(4'd3, 32'd0);
        push(32'h11, 0);
        bus_write(4'd0, 32'd1);
        wait_idle("t5a_idle", 50);
        check("t5a_drained", 32'(exp_q.size()), 32'd0);
        read_check("t5a_status", 4'd1, 32'h02);
        bus_write(4'd1, 32'h2);
        read_check("t5a_done_clr", 4'd1, 32'h00);
        bus_write(4'd3, 32'd20);
        read_check("t5_len_rd", 4'd3, 32'd20);
        push(32'h11, 0);
        for (int i = 1; i < 8; i++) begin
            push(32'(8'h11 * (i + 1)), 2);
        end
        bus_write(4'd0, 32'd1);
        wait_idle("t5b_idle", 100);
        check("t5b_drained", 32'(exp_q.size()), 32'd0);
        read_check("t5b_status", 4'd1, 32'h72);
        bus_write(4'd1, 32'h2);

        // T6 completion on the same edge as a done-clear
        bus_write(4'd3, 32'd1);
        bus_write(4'd2, 32'd3);
        push(32'h11, 0);
        bus_write(4'd0, 32'd5);
        bus_write(4'd1, 32'h2);
        check("t6_irq_set", 32'(irq), 32'd1);
        read_check("t6_status", 4'd1, 32'h02);
        bus_write(4'd1, 32'h2);
        check("t6_irq_clr", 32'(irq), 32'd0);
        read_check("t6_status_clr", 4'd1, 32'h00);
        read_check("t6_ctrl", 4'd0, 32'h4);

        // T1 asynchronous reset during a stalled write
        push(32'h11, 0);
        bus_write(4'd0, 32'd5);
        repeat (3) @(posedge clk);
        #1;
        avm_waitrequest = 1'b1;
        push(32'h11, 0);
        bus_write(4'd0, 32'd5);
        repeat (2) @(posedge clk);
        #1;
        check("t1_pre_write", 32'(avm_write), 32'd1);
        check("t1_pre_irq", 32'(irq), 32'd1);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("t1_avm_write", 32'(avm_write), 32'd0);
        check("t1_irq", 32'(irq), 32'd0);
        for (int a = 0; a < 4; a++) begin
            address = 4'(a);
            #1;
            check("t1_reg", readdata, 32'd0);
        end
        address = 4'd8;
        #1;
        check("t1_pat0", readdata, 32'd0);
        @(posedge clk);
        #1;
        avm_waitrequest = 1'b0;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("t1_post_write", 32'(avm_write), 32'd0);
        read_check("t1_post_ctrl", 4'd0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
